prescaled_mode_counter: RTL and testbench
=========================================

// Module: prescaled_mode_counter
// PURPOSE
//  Next-generation LED counter. A DIV-cycle prescaler drives a WIDTH-bit up/down counter.
//  The counter has a programmable terminal value, a synchronous load, and four modes:
//  WRAP, SATURATE, BOUNCE and ONESHOT. It sits between the board clock and the LED bank,
//  and flags boundary events (tc) for downstream sequencing logic.
// PARAMETERS
//  WIDTH  4  counter / LED width, >=1
//  DIV    5  prescaler ratio: one count step per DIV enabled clocks, >=1 (DIV=1: step every enabled clk)
// PORTS
//  clk         in   1      single clock, all state on posedge
//  reset_n     in   1      asynchronous, active-low reset
//  enable      in   1      1: prescaler runs; 0: prescaler and counter hold
//  dir         in   1      1 up, 0 down; used in WRAP/SATURATE/ONESHOT; seeds BOUNCE direction on load
//  mode        in   2      mode_e: 0 WRAP, 1 SATURATE, 2 BOUNCE, 3 ONESHOT
//  load        in   1      synchronous load strobe
//  load_value  in   WIDTH  value written on load
//  max_value   in   WIDTH  upper bound; lower bound is always 0
//  leds        out  WIDTH  current count (registered)
//  tick        out  1      one-cycle pulse, coincident with each count step
//  tc          out  1      one-cycle pulse on a boundary event
//  dir_out     out  1      effective direction of the last/next step (registered)
//  done        out  1      ONESHOT finished; sticky until load
// BEHAVIOUR
//  Reset: asynchronous, any cycle, including mid-prescale.
//   Forces prescaler=0, leds=0, tick=0, tc=0, done=0, dir_out=1, bounce_dir=1.
//  Prescaler: counts 0..DIV-1 while enable=1 and holds its value while enable=0.
//   Step edge = posedge at which prescaler==DIV-1 and enable=1.
//   On the step edge: prescaler<=0, tick<=1, and leds<=next value, all on the same edge.
//   First step is exactly DIV enabled cycles after the prescaler was 0.
//  Load priority: load > step.
//   load=1 => prescaler<=0, leds<=load_value, bounce_dir<=dir, done<=0; tick<=0, tc<=0 that edge.
//  Direction: dir and mode are sampled only on step edges.
//   eff_dir = bounce_dir in BOUNCE, dir otherwise; dir_out<=eff_dir on each step.
//  Boundary event:
//   - step with eff_dir=1 and leds>=max_value, or
//   - step with eff_dir=0 and leds==0.
//   tc<=1 on that step edge only.
//  Next value at a non-boundary step: leds+1 or leds-1.
//  Next value at a boundary step, per mode:
//   WRAP      up: 0; down: max_value
//   SATURATE  hold leds (up clamps to max_value if leds>max_value); tc pulses on every boundary step
//   BOUNCE    bounce_dir<=~bounce_dir; step once in the new direction (max=3 gives 2, at 0 gives 1);
//             max_value=0 holds 0
//   ONESHOT   hold, done<=1; while done=1, step edges still pulse tick but leds, tc, dir_out hold
//  Width rules:
//   - all arithmetic is in WIDTH bits;
//   - no wrap through 2^WIDTH except via WRAP mode;
//   - load_value>max_value is accepted, and the next up step is a boundary event.
//  max_value or mode changes mid-run take effect at the next step edge. No other latency.
// STRUCTURE
//  counter_pkg:
//   - typedef enum logic [1:0] mode_e {MODE_WRAP, MODE_SATURATE, MODE_BOUNCE, MODE_ONESHOT};
//   - localparam DIR_UP=1'b1, DIR_DOWN=1'b0.
//  Sub-module tick_prescaler #(DIV)
//   - ports: clk, reset_n, enable, clear, tick_en (combinational step-edge qualifier);
//     counter width $clog2(DIV) with a minimum of 1.
//  Top keeps leds / bounce_dir / done / tick / tc / dir_out registers and the next-value case on mode_e.
// TESTING  (WIDTH=4, DIV=5, max_value=9 unless noted; clk period 10)
//  1 WRAP up, enable from cycle 0
//    -> leds 1,2,..,9,0 every 5 clks; tc only on 9->0; tick 1-cycle each step.
//  2 SATURATE down, load 2
//    -> leds 1,0,0,0; tc on each step taken at 0; dir_out=0.
//  3 BOUNCE, max_value=3, load 0 with dir=1
//    -> leds 1,2,3,2,1,0,1; tc on the 3->2 and 0->1 steps; dir_out follows.
//  4 ONESHOT up, max_value=3, load 0
//    -> 1,2,3, then boundary: tc once, done=1, leds stays 3 over 4 more ticks;
//       load 5 clears done, leds=5.
//  5 Prescaler control: enable=0 for 7 clks mid-prescale (prescaler=3)
//    -> no tick, resumes after 2 more enabled clks.
//    Load asserted on a step edge -> leds=load_value, no tick/tc that edge, next tick 5 clks later.
//  6 reset_n low for 1 ns, between edges, mid-run (leds=6, done=1)
//    -> leds=0, tick=0, tc=0, done=0, dir_out=1 immediately;
//       after release, first step after 5 enabled clks.

Source files
------------

// File: rtl/prescaled_mode_counter_pkg.sv
// Shared types for the prescaled mode counter: counting modes and direction encodings.
package counter_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP     = 2'd0,
        MODE_SATURATE = 2'd1,
        MODE_BOUNCE   = 2'd2,
        MODE_ONESHOT  = 2'd3
    } mode_e;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/tick_prescaler.sv
// Divide-by-DIV prescaler; tick_en marks the enabled clock that completes a DIV-cycle period.
module tick_prescaler #(
    parameter int unsigned DIV = 5
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    input  logic clear,
    output logic tick_en
);

    localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] cnt;

    assign tick_en = enable && (cnt == LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clear || tick_en) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + PW'(1);
        end
    end

endmodule

// File: rtl/prescaled_mode_counter.sv
// LED counter stepped by a DIV-cycle prescaler, with load, terminal value and four boundary modes.
module prescaled_mode_counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DIV   = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic [WIDTH-1:0] max_value,
    output logic [WIDTH-1:0] leds,
    output logic             tick,
    output logic             tc,
    output logic             dir_out,
    output logic             done
);

    logic             step;
    logic             bounce_dir;
    mode_e            mode_sel;
    logic             eff_dir;
    logic             at_bound;
    logic [WIDTH-1:0] next_leds;
    logic             next_bdir;
    logic             next_done;

    tick_prescaler #(.DIV(DIV)) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (enable),
        .clear   (load),
        .tick_en (step)
    );

    always_comb begin
        mode_sel  = mode_e'(mode);
        eff_dir   = (mode_sel == MODE_BOUNCE) ? bounce_dir : dir;
        at_bound  = (eff_dir == DIR_UP) ? (leds >= max_value) : (leds == '0);
        next_leds = leds;
        next_bdir = bounce_dir;
        next_done = done;
        if (!at_bound) begin
            next_leds = (eff_dir == DIR_UP) ? leds + WIDTH'(1) : leds - WIDTH'(1);
        end else begin
            case (mode_sel)
                MODE_WRAP: begin
                    next_leds = (eff_dir == DIR_UP) ? '0 : max_value;
                end
                MODE_SATURATE: begin
                    if (eff_dir == DIR_UP && leds > max_value) begin
                        next_leds = max_value;
                    end
                end
                MODE_BOUNCE: begin
                    // Reverse, then take one step the other way; guards keep 0 from wrapping.
                    next_bdir = ~bounce_dir;
                    if (eff_dir == DIR_UP) begin
                        next_leds = (leds == '0) ? '0 : leds - WIDTH'(1);
                    end else begin
                        next_leds = (max_value == '0) ? '0 : WIDTH'(1);
                    end
                end
                MODE_ONESHOT: begin
                    next_done = 1'b1;
                end
                default: begin
                    next_leds = leds;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            leds       <= '0;
            tick       <= 1'b0;
            tc         <= 1'b0;
            done       <= 1'b0;
            dir_out    <= DIR_UP;
            bounce_dir <= DIR_UP;
        end else if (load) begin
            leds       <= load_value;
            bounce_dir <= dir;
            done       <= 1'b0;
            tick       <= 1'b0;
            tc         <= 1'b0;
        end else if (step) begin
            tick <= 1'b1;
            if (done) begin
                tc <= 1'b0;
            end else begin
                leds       <= next_leds;
                tc         <= at_bound;
                dir_out    <= eff_dir;
                bounce_dir <= next_bdir;
                done       <= next_done;
            end
        end else begin
            tick <= 1'b0;
            tc   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_prescaled_mode_counter.sv
// Directed and randomized checks of prescaled_mode_counter against a behavioural model.
module tb_prescaled_mode_counter;

    localparam int DIV = 5;

    logic       clk;
    logic       reset_n;
    logic       enable;
    logic       dir;
    logic [1:0] mode;
    logic       load;
    logic [3:0] load_value;
    logic [3:0] max_value;
    logic [3:0] leds;
    logic       tick;
    logic       tc;
    logic       dir_out;
    logic       done;

    int checks = 0;
    int errors = 0;

    int m_pre, m_leds, m_bdir, m_done, m_tick, m_tc, m_dout;

    prescaled_mode_counter #(.WIDTH(4), .DIV(DIV)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .dir        (dir),
        .mode       (mode),
        .load       (load),
        .load_value (load_value),
        .max_value  (max_value),
        .leds       (leds),
        .tick       (tick),
        .tc         (tc),
        .dir_out    (dir_out),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pre = 0; m_leds = 0; m_bdir = 1; m_done = 0;
        m_tick = 0; m_tc = 0; m_dout = 1;
    endtask

    // One clock edge of the reference model, from the counting rules in plain integers.
    task automatic model_edge();
        int mx, up, hit;
        mx = int'(max_value);
        if (load) begin
            m_pre = 0; m_leds = int'(load_value); m_bdir = int'(dir);
            m_done = 0; m_tick = 0; m_tc = 0;
        end else if (enable && m_pre == DIV - 1) begin
            m_pre = 0;
            m_tick = 1;
            if (m_done == 1) begin
                m_tc = 0;
            end else begin
                up = (mode == 2'd2) ? m_bdir : int'(dir);
                m_dout = up;
                hit = up ? (m_leds >= mx) : (m_leds == 0);
                m_tc = hit;
                if (!hit) begin
                    m_leds = up ? m_leds + 1 : m_leds - 1;
                end else if (mode == 2'd0) begin
                    m_leds = up ? 0 : mx;
                end else if (mode == 2'd1) begin
                    if (up && m_leds > mx) m_leds = mx;
                end else if (mode == 2'd2) begin
                    m_bdir = 1 - m_bdir;
                    if (up) m_leds = (m_leds == 0) ? 0 : m_leds - 1;
                    else    m_leds = (mx == 0) ? 0 : 1;
                end else begin
                    m_done = 1;
                end
            end
        end else begin
            if (enable) m_pre = m_pre + 1;
            m_tick = 0;
            m_tc = 0;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_leds"}, 32'(leds), 32'(m_leds));
        chk({tag, "_tick"}, 32'(tick), 32'(m_tick));
        chk({tag, "_tc"}, 32'(tc), 32'(m_tc));
        chk({tag, "_dir_out"}, 32'(dir_out), 32'(m_dout));
        chk({tag, "_done"}, 32'(done), 32'(m_done));
    endtask

    task automatic clk_step();
        @(posedge clk);
        model_edge();
        #1;
        check_all("cyc");
    endtask

    task automatic do_load(input logic [3:0] v);
        load = 1'b1;
        load_value = v;
        clk_step();
        load = 1'b0;
    endtask

    initial begin
        int exp3_leds[7] = '{1, 2, 3, 2, 1, 0, 1};
        int exp3_tc[7]   = '{0, 0, 0, 1, 0, 0, 1};
        int exp4_leds[7] = '{1, 2, 3, 3, 3, 3, 3};
        int exp4_tc[7]   = '{0, 0, 0, 1, 0, 0, 0};
        int exp4_done[7] = '{0, 0, 0, 1, 1, 1, 1};
        int exp2_leds[4] = '{1, 0, 0, 0};
        int exp2_tc[4]   = '{0, 0, 1, 1};

        reset_n = 1'b0; enable = 1'b1; dir = 1'b1; mode = 2'd0;
        load = 1'b0; load_value = '0; max_value = 4'd9;
        model_reset();
        #12;
        check_all("reset");
        reset_n = 1'b1;

        // WRAP up from reset
        for (int k = 1; k <= 10; k++) begin
            repeat (DIV) clk_step();
            chk("t1_leds", 32'(leds), 32'(k % 10));
            chk("t1_tc", 32'(tc), 32'(k == 10));
        end

        // SATURATE down from 2
        mode = 2'd1; dir = 1'b0;
        do_load(4'd2);
        for (int i = 0; i < 4; i++) begin
            repeat (DIV) clk_step();
            chk("t2_leds", 32'(leds), 32'(exp2_leds[i]));
            chk("t2_tc", 32'(tc), 32'(exp2_tc[i]));
            chk("t2_dir_out", 32'(dir_out), 32'd0);
        end

        // BOUNCE between 0 and 3
        mode = 2'd2; dir = 1'b1; max_value = 4'd3;
        do_load(4'd0);
        for (int i = 0; i < 7; i++) begin
            repeat (DIV) clk_step();
            chk("t3_leds", 32'(leds), 32'(exp3_leds[i]));
            chk("t3_tc", 32'(tc), 32'(exp3_tc[i]));
        end

        // ONESHOT up to 3, then reload clears done
        mode = 2'd3; dir = 1'b1; max_value = 4'd3;
        do_load(4'd0);
        for (int i = 0; i < 7; i++) begin
            repeat (DIV) clk_step();
            chk("t4_leds", 32'(leds), 32'(exp4_leds[i]));
            chk("t4_tc", 32'(tc), 32'(exp4_tc[i]));
            chk("t4_done", 32'(done), 32'(exp4_done[i]));
            chk("t4_tick", 32'(tick), 32'd1);
        end
        do_load(4'd5);
        chk("t4_reload_leds", 32'(leds), 32'd5);
        chk("t4_reload_done", 32'(done), 32'd0);

        // Enable gap mid-prescale, then load on a step edge
        mode = 2'd0; dir = 1'b1; max_value = 4'd9;
        do_load(4'd0);
        repeat (3) clk_step();
        enable = 1'b0;
        for (int i = 0; i < 7; i++) begin
            clk_step();
            chk("t5_hold_tick", 32'(tick), 32'd0);
        end
        enable = 1'b1;
        clk_step();
        chk("t5_resume1_tick", 32'(tick), 32'd0);
        clk_step();
        chk("t5_resume2_tick", 32'(tick), 32'd1);
        chk("t5_resume2_leds", 32'(leds), 32'd1);
        repeat (DIV - 1) clk_step();
        do_load(4'd7);
        chk("t5_load_leds", 32'(leds), 32'd7);
        chk("t5_load_tick", 32'(tick), 32'd0);
        chk("t5_load_tc", 32'(tc), 32'd0);
        repeat (DIV - 1) clk_step();
        chk("t5_pre_tick", 32'(tick), 32'd0);
        clk_step();
        chk("t5_next_tick", 32'(tick), 32'd1);
        chk("t5_next_leds", 32'(leds), 32'd8);

        // Asynchronous reset between edges while done is set
        mode = 2'd3; dir = 1'b1; max_value = 4'd6;
        do_load(4'd0);
        repeat (7 * DIV) clk_step();
        chk("t6_pre_leds", 32'(leds), 32'd6);
        chk("t6_pre_done", 32'(done), 32'd1);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("t6_rst_leds", 32'(leds), 32'd0);
        chk("t6_rst_tick", 32'(tick), 32'd0);
        chk("t6_rst_tc", 32'(tc), 32'd0);
        chk("t6_rst_done", 32'(done), 32'd0);
        chk("t6_rst_dir_out", 32'(dir_out), 32'd1);
        reset_n = 1'b1;
        repeat (DIV - 1) clk_step();
        chk("t6_post_pre_tick", 32'(tick), 32'd0);
        clk_step();
        chk("t6_post_tick", 32'(tick), 32'd1);
        chk("t6_post_leds", 32'(leds), 32'd1);

        // Randomized mix of all inputs against the model
        for (int i = 0; i < 600; i++) begin
            enable     = ($urandom_range(3) != 0);
            dir        = 1'($urandom_range(1));
            mode       = 2'($urandom_range(3));
            load       = ($urandom_range(15) == 0);
            load_value = 4'($urandom_range(15));
            if ($urandom_range(7) == 0) max_value = 4'($urandom_range(15));
            clk_step();
        end
        load = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
